// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester sequencer/arbiter for a shared 3-bit arithmetic unit.
// ALU_ARB_FAIR_EN selects round-robin arbitration; default is fixed priority to req0.
module alu_arbiter #(
    parameter int W  = 3,
    parameter int RW = 2 * W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [2:0]    req0_op,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [2:0]    req1_op,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    output logic [2:0]    alu_op,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [RW-1:0] alu_y,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [RW-1:0] rsp_data,
    output logic          rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state, state_nxt;
    logic   grant0, grant1, accept, op_err;

`ifdef ALU_ARB_FAIR_EN
    logic last_id;

    // last_id == 1 means req1 went last, so req0 takes a tie
    assign grant0 = req0_valid & (~req1_valid | last_id);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id <= 1'b1;
        end else if (accept) begin
            last_id <= grant1;
        end
    end
`else
    assign grant0 = req0_valid;
`endif

    assign grant1     = req1_valid & ~grant0;
    assign accept     = (state == IDLE) & (grant0 | grant1);
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;
    assign rsp_valid  = (state == RESP);

    assign op_err = (alu_op >= 3'd5)
                  | (((alu_op == 3'd3) | (alu_op == 3'd4)) & (alu_b == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            alu_op <= grant1 ? req1_op : req0_op;
            alu_a  <= grant1 ? req1_a : req0_a;
            alu_b  <= grant1 ? req1_b : req0_b;
            rsp_id <= grant1;
        end else if (state == ISSUE) begin
            rsp_data <= op_err ? '0 : alu_y;
            rsp_err  <= op_err;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural arithmetic unit.
module tb_alu_arbiter;

    localparam int W  = 3;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [2:0]    req0_op = '0, req1_op = '0;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]    alu_op;
    logic [W-1:0]  alu_a, alu_b;
    logic [RW-1:0] alu_y;
    logic          rsp_valid, rsp_id, rsp_err;
    logic          rsp_ready = 1'b1;
    logic [RW-1:0] rsp_data;

    typedef struct packed {
        logic          id;
        logic [RW-1:0] data;
        logic          err;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_arbiter #(.W(W), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Unit model: garbage on illegal ops so the block's zeroing is visible
    always_comb begin
        alu_y = 6'h2A;
        case (alu_op)
            3'd0: alu_y = {3'b0, alu_a} + {3'b0, alu_b};
            3'd1: alu_y = {3'b0, alu_a - alu_b};
            3'd2: alu_y = {3'b0, alu_a} * {3'b0, alu_b};
            3'd3: alu_y = (alu_b == 0) ? 6'h3F : {3'b0, alu_a / alu_b};
            3'd4: alu_y = (alu_b == 0) ? 6'h3F : {3'b0, alu_a % alu_b};
            default: alu_y = 6'h2A;
        endcase
    end

    function automatic rsp_t exp_rsp(logic id, logic [2:0] op,
                                     logic [W-1:0] a, logic [W-1:0] b);
        rsp_t r;
        r.id   = id;
        r.err  = 1'b0;
        r.data = '0;
        case (op)
            3'd0: r.data = 6'(int'(a) + int'(b));
            3'd1: r.data = 6'((int'(a) - int'(b) + 8) % 8);
            3'd2: r.data = 6'(int'(a) * int'(b));
            3'd3: if (b == 0) r.err = 1'b1; else r.data = 6'(int'(a) / int'(b));
            3'd4: if (b == 0) r.err = 1'b1; else r.data = 6'(int'(a) % int'(b));
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected id=%0d data=%0d err=%0d",
                         rsp_id, rsp_data, rsp_err);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                if ({rsp_id, rsp_data, rsp_err} !== e) begin
                    errors++;
                    $display("FAIL rsp_scoreboard got id=%0d data=%0d err=%0d exp id=%0d data=%0d err=%0d",
                             rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(logic id, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accept edge
    task automatic issue(logic id, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        bit got = 0;
        set_req(id, op, a, b);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                got = 1;
                sb.push_back(exp_rsp(id, op, a, b));
            end
            @(posedge clk); #1;
        end
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL issue_timeout id=%0d got=0 exp=1", id);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && (sb.size() != 0 || rsp_valid); n++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({alu_op, alu_a, alu_b} !== '0) begin
            errors++;
            $display("FAIL reset_alu got op=%0d a=%0d b=%0d exp 0", alu_op, alu_a, alu_b);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_rsp got v=%0d id=%0d err=%0d data=%0d exp 0",
                     rsp_valid, rsp_id, rsp_err, rsp_data);
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_mul_timing();
        set_req(0, 3'd2, 3'd7, 3'd5);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL mul_ready got %b exp 10", {req0_ready, req1_ready});
        end
        sb.push_back(exp_rsp(0, 3'd2, 3'd7, 3'd5));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({alu_op, alu_a, alu_b, rsp_valid} !== {3'd2, 3'd7, 3'd5, 1'b0}) begin
            errors++;
            $display("FAIL mul_issue got op=%0d a=%0d b=%0d v=%0d exp 2 7 5 0",
                     alu_op, alu_a, alu_b, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, 6'd35, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mul_resp got v=%0d data=%0d id=%0d err=%0d exp 1 35 0 0",
                     rsp_valid, rsp_data, rsp_id, rsp_err);
        end
        drain();
    endtask

    task automatic test_errors();
        issue(1, 3'd3, 3'd6, 3'd0);
        drain();
        issue(0, 3'd6, 3'd3, 3'd2);
        drain();
        issue(1, 3'd6, 3'd1, 3'd1);
        drain();
        issue(0, 3'd4, 3'd5, 3'd0);
        drain();
    endtask

    task automatic test_arith();
        issue(0, 3'd1, 3'd2, 3'd5);
        drain();
        issue(0, 3'd0, 3'd7, 3'd7);
        drain();
        issue(1, 3'd3, 3'd7, 3'd2);
        drain();
        issue(1, 3'd4, 3'd7, 3'd3);
        drain();
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_g;
        int k = 0;
`ifdef ALU_ARB_FAIR_EN
        exp_g = 4'b1010;
`else
        exp_g = 4'b0000;
`endif
        apply_reset();
        set_req(0, 3'd0, 3'd1, 3'd2);
        set_req(1, 3'd2, 3'd3, 3'd3);
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                checks++;
                if ((req0_ready & req1_ready) || req1_ready !== exp_g[k]) begin
                    errors++;
                    $display("FAIL arb_grant%0d got r0=%0d r1=%0d exp grant=%0d",
                             k, req0_ready, req1_ready, exp_g[k]);
                end
                if (req1_ready) sb.push_back(exp_rsp(1, 3'd2, 3'd3, 3'd3));
                else            sb.push_back(exp_rsp(0, 3'd0, 3'd1, 3'd2));
                k++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL arb_count got %0d exp 4", k);
        end
        drain();
    endtask

    task automatic test_stall();
        rsp_ready = 1'b0;
        issue(0, 3'd4, 3'd7, 3'd3);
        set_req(1, 3'd0, 3'd2, 3'd3);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready}
                    !== {1'b1, 6'd1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%0d data=%0d id=%0d r0=%0d r1=%0d exp 1 1 0 0 0",
                         i, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL stall_release got v=%0d r1=%0d exp 0 1", rsp_valid, req1_ready);
        end
        if (req1_ready) sb.push_back(exp_rsp(1, 3'd0, 3'd2, 3'd3));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        bit got = 0;
        set_req(0, 3'd2, 3'd3, 3'd3);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = req0_ready;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_err, rsp_data} !== '0 || !got) begin
            errors++;
            $display("FAIL midreset_clear got op=%0d a=%0d b=%0d v=%0d data=%0d accepted=%0d exp 0s accepted=1",
                     alu_op, alu_a, alu_b, rsp_valid, rsp_data, got);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_no_rsp got %0d cycles exp 0", seen);
        end
        @(posedge clk); #1;
        set_req(0, 3'd0, 3'd3, 3'd4);
        set_req(1, 3'd0, 3'd1, 3'd1);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_first_grant got %b exp 10", {req0_ready, req1_ready});
        end
        if (req0_ready) sb.push_back(exp_rsp(0, 3'd0, 3'd3, 3'd4));
        if (req1_ready) sb.push_back(exp_rsp(1, 3'd0, 3'd1, 3'd1));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_mul_timing();
        test_errors();
        test_arith();
        test_arbitration();
        test_stall();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
